// File: rtl/fc_config_regfile_pkg.sv
// Shared definitions for the flight-controller I2C configuration register file.
package fc_config_pkg;

  localparam int         FC_PTR_W        = 8;
  localparam logic [6:0] FC_DEFAULT_ADDR = 7'h51;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fc_config_regfile_if.sv
// Register-side bundle: status bytes in, control bytes and write strobes out.
interface fc_config_regfile_if #(
  parameter int NUM_RO = 1,
  parameter int NUM_RW = 2
);
  logic [8*NUM_RO-1:0] ro_data;
  logic [8*NUM_RW-1:0] rw_data;
  logic [NUM_RW-1:0]   rw_wr_strobe;

  modport slave  (input ro_data, output rw_data, rw_wr_strobe);
  modport master (output ro_data, input rw_data, rw_wr_strobe);
endinterface

// File: rtl/fc_config_regfile_i2c_slave.sv
// Byte-level I2C slave core: oversamples SCL/SDA in the core clock and exposes
// address-match, direction, received byte and next-byte-request levels.
module i2c_slave
  import fc_config_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = FC_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic       slave_asserted,
  output logic       slave_in_tx_mode,
  output logic       slave_tx_request,
  output logic       slave_rx_available,
  output logic [7:0] slave_rx_buffer,
  input  logic [7:0] slave_tx_buffer
);

  // [1] is the synchronised sample, [2] the previous one
  logic [2:0] scl_sync, sda_sync;
  logic       sda_in, scl_rise, scl_fall, start_det, stop_det;
  logic       active, addr_phase;
  logic [3:0] bit_cnt;
  logic [6:0] shift, tx_shift;

  assign sda_in    = sda_sync[1];
  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign start_det = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
  assign stop_det  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync           <= '1;
      sda_sync           <= '1;
      active             <= 1'b0;
      addr_phase         <= 1'b0;
      bit_cnt            <= '0;
      shift              <= '0;
      tx_shift           <= '0;
      sda_oe             <= 1'b0;
      slave_asserted     <= 1'b0;
      slave_in_tx_mode   <= 1'b0;
      slave_tx_request   <= 1'b0;
      slave_rx_available <= 1'b0;
      slave_rx_buffer    <= '0;
    end else begin
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda};
      if (start_det) begin
        active             <= 1'b1;
        addr_phase         <= 1'b1;
        bit_cnt            <= '0;
        sda_oe             <= 1'b0;
        slave_asserted     <= 1'b0;
        slave_in_tx_mode   <= 1'b0;
        slave_tx_request   <= 1'b0;
        slave_rx_available <= 1'b0;
      end else if (stop_det) begin
        active             <= 1'b0;
        sda_oe             <= 1'b0;
        slave_asserted     <= 1'b0;
        slave_tx_request   <= 1'b0;
        slave_rx_available <= 1'b0;
      end else if (active && scl_rise) begin
        if (bit_cnt < 4'd8) begin
          shift   <= {shift[5:0], sda_in};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (addr_phase) begin
              if (shift == SLAVE_ADDR) begin
                slave_asserted   <= 1'b1;
                slave_in_tx_mode <= sda_in;
              end else begin
                active <= 1'b0;
              end
            end else if (!slave_in_tx_mode) begin
              slave_rx_buffer    <= {shift, sda_in};
              slave_rx_available <= 1'b1;
            end
          end
        end else if (bit_cnt == 4'd8) begin
          bit_cnt <= 4'd9;
          // Request the next byte only when the master will actually clock it out
          if (slave_in_tx_mode) begin
            if (addr_phase || !sda_in) slave_tx_request <= 1'b1;
            else                       active           <= 1'b0;
          end
        end
      end else if (active && scl_fall) begin
        if (bit_cnt == 4'd8) begin
          sda_oe <= !slave_in_tx_mode || addr_phase;
        end else if (bit_cnt == 4'd9) begin
          bit_cnt            <= '0;
          addr_phase         <= 1'b0;
          slave_tx_request   <= 1'b0;
          slave_rx_available <= 1'b0;
          if (slave_in_tx_mode) begin
            tx_shift <= slave_tx_buffer[6:0];
            sda_oe   <= ~slave_tx_buffer[7];
          end else begin
            sda_oe <= 1'b0;
          end
        end else if (slave_in_tx_mode && !addr_phase && bit_cnt != 4'd0) begin
          tx_shift <= {tx_shift[5:0], 1'b0};
          sda_oe   <= ~tx_shift[6];
        end
      end
    end
  end

endmodule

// File: rtl/fc_config_regfile.sv
// I2C-accessible window of NUM_RO status bytes followed by NUM_RW masked control
// bytes, with auto-incrementing pointer and per-register write strobes.
module fc_config_regfile
  import fc_config_pkg::*;
#(
  parameter logic [6:0]          SLAVE_ADDR = FC_DEFAULT_ADDR,
  parameter int                  NUM_RO     = 1,
  parameter int                  NUM_RW     = 2,
  parameter logic [8*NUM_RW-1:0] RW_RESET   = '0,
  parameter logic [8*NUM_RW-1:0] RW_WMASK   = '1
) (
  input  logic               clk_core,
  input  logic               reset_n,
  input  logic               i2c_clk,
  inout  wire                i2c_sda,
  fc_config_regfile_if.slave regs
);

  localparam int                  NUM_REGS = NUM_RO + NUM_RW;
  localparam logic [FC_PTR_W-1:0] LAST_PTR = FC_PTR_W'(NUM_REGS - 1);

  logic       slave_asserted, slave_in_tx_mode, slave_tx_request, slave_rx_available;
  logic       sda_oe;
  logic [7:0] slave_rx_buffer, slave_tx_buffer;

  i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR)) u_i2c_slave (
    .clk                (clk_core),
    .reset_n            (reset_n),
    .scl                (i2c_clk),
    .sda                (i2c_sda),
    .sda_oe             (sda_oe),
    .slave_asserted     (slave_asserted),
    .slave_in_tx_mode   (slave_in_tx_mode),
    .slave_tx_request   (slave_tx_request),
    .slave_rx_available (slave_rx_available),
    .slave_rx_buffer    (slave_rx_buffer),
    .slave_tx_buffer    (slave_tx_buffer)
  );

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  // Rising-edge detect on the core's request levels; ev is high two cycles after the edge
  logic [1:0] tx_hist, rx_hist;
  logic       tx_ev, rx_ev;

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      tx_hist <= '0;
      rx_hist <= '0;
      tx_ev   <= 1'b0;
      rx_ev   <= 1'b0;
    end else begin
      tx_hist <= {tx_hist[0], slave_tx_request};
      rx_hist <= {rx_hist[0], slave_rx_available};
      tx_ev   <= tx_hist[0] & ~tx_hist[1];
      rx_ev   <= rx_hist[0] & ~rx_hist[1];
    end
  end

  fc_state_e           state, state_nxt;
  logic [FC_PTR_W-1:0] ptr, ptr_nxt, ptr_inc;
  logic [7:0]          rd_byte;
  logic                do_tx, do_wr;
  logic [8*NUM_RW-1:0] rw_flat;
  logic [NUM_RW-1:0]   stb_flat;

  assign ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    do_tx     = 1'b0;
    do_wr     = 1'b0;
    if (!slave_asserted) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_ADDR;
        ST_ADDR, ST_DATA: begin
          if (slave_in_tx_mode) begin
            if (tx_ev) begin
              do_tx   = 1'b1;
              ptr_nxt = ptr_inc;
            end
          end else if (rx_ev) begin
            if (state == ST_ADDR) begin
              ptr_nxt   = slave_rx_buffer;
              state_nxt = ST_DATA;
            end else begin
              do_wr   = 1'b1;
              ptr_nxt = ptr_inc;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    for (int j = 0; j < NUM_RO; j++)
      if (ptr == FC_PTR_W'(j)) rd_byte = regs.ro_data[8*j +: 8];
    for (int i = 0; i < NUM_RW; i++)
      if (ptr == FC_PTR_W'(NUM_RO + i)) rd_byte = rw_flat[8*i +: 8];
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      slave_tx_buffer <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (do_tx) slave_tx_buffer <= rd_byte;
    end
  end

  // Writes that miss every RW slot (RO or out-of-range pointer) simply fall through
  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    localparam logic [7:0] MASK = RW_WMASK[8*i +: 8];
    localparam logic [7:0] RST  = RW_RESET[8*i +: 8];
    logic       hit, stb;
    logic [7:0] q;

    assign hit = do_wr && (ptr == FC_PTR_W'(NUM_RO + i));

    always_ff @(posedge clk_core) begin
      if (!reset_n) begin
        q   <= RST;
        stb <= 1'b0;
      end else begin
        stb <= hit;
        if (hit) q <= (q & ~MASK) | (slave_rx_buffer & MASK);
      end
    end

    assign rw_flat[8*i +: 8] = q;
    assign stb_flat[i]       = stb;
  end

  assign regs.rw_data      = rw_flat;
  assign regs.rw_wr_strobe = stb_flat;

endmodule

// File: doc/fc_config_regfile.md
# fc_config_regfile

Parametrised I2C-accessible configuration register file for the flight-controller FPGA, and the successor to the fixed three-register config block. It instantiates the existing `i2c_slave` core and exposes a window of `NUM_RO` read-only status bytes followed by `NUM_RW` read/write control bytes. It adds per-register reset values, per-bit write masks, multi-byte auto-increment writes, write strobes, and a synchronous active-low reset.

## Interface
Parameters:
- `SLAVE_ADDR`, default 7'h51: 7-bit I2C slave address.
- `NUM_RO`, default 1: number of read-only registers, at addresses 0..NUM_RO-1. Must be ≥1.
- `NUM_RW`, default 2: number of RW registers, at addresses NUM_RO..NUM_RO+NUM_RW-1. Must be ≥1. NUM_RO+NUM_RW ≤ 256.
- `RW_RESET`, default 0: flat [8*NUM_RW-1:0] reset values. Byte i belongs to RW register i.
- `RW_WMASK`, default all-ones: flat [8*NUM_RW-1:0] writable-bit masks. A 0 bit is write-protected.

Ports:
- `clk_core`, input, 1: core clock. One clock domain; all logic on its rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `i2c_clk`, input, 1: I2C SCL from master.
- `i2c_sda`, inout, 1: I2C SDA.
- `ro_data`, input, 8*NUM_RO: status bytes. Byte j is served at address j.
- `rw_data`, output, 8*NUM_RW: control register contents.
- `rw_wr_strobe`, output, NUM_RW: one-cycle pulse per RW register when it is written.

## Operation
- Register address space: NUM_REGS = NUM_RO+NUM_RW. `ptr` is an 8-bit register pointer.
- Event detection:
  - `slave_tx_request` and `slave_rx_available` each pass through a 2-flop history.
  - A registered rising-edge pulse is generated from that history, giving `tx_ev` and `rx_ev`.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: entered whenever `slave_asserted`=0, from any state. Moves to ADDR when `slave_asserted`=1.
  - ADDR, on `rx_ev` in rx mode: `ptr` ← rx byte, go to DATA.
  - DATA, on `rx_ev`: write to register `ptr`, then `ptr` ← next(ptr). Stays in DATA for any number of bytes; there is no counter wrap back to address capture.
  - Any asserted state, in tx mode, on `tx_ev`: `slave_tx_buffer` ← read(ptr), then `ptr` ← next(ptr). The FSM state is unchanged.
- `ptr` is retained across IDLE. This supports a write-pointer transfer followed by a repeated-start or separate read.
- next(ptr) = 0 if ptr == NUM_REGS-1, else ptr+1 in 8 bits (255 wraps to 0).
- read(p) returns:
  - `ro_data` byte p when p < NUM_RO;
  - `rw_data` byte p-NUM_RO when p < NUM_REGS;
  - 8'h00 otherwise.
- write(p, d):
  - Applies only when NUM_RO ≤ p < NUM_REGS. Let i = p-NUM_RO.
  - rw[i] ← (rw[i] & ~WMASK[i]) | (d & WMASK[i]).
  - `rw_wr_strobe[i]` is pulsed, even if the mask is zero.
  - Writes to RO or out-of-range addresses are discarded, but `ptr` still advances.
- Mode selects the event: `slave_in_tx_mode`=1 considers only `tx_ev`; otherwise only `rx_ev`.

## Timing
- Reset values:
  - `rw_data` = RW_RESET;
  - `rw_wr_strobe` = 0;
  - `slave_tx_buffer` = 0;
  - `ptr` = 0;
  - FSM = IDLE;
  - edge histories and pulses = 0.
- Reset has priority over all events. Reset mid-transfer aborts it, and the FSM requires a fresh assert to leave IDLE.
- Event latency: a strobe rising at cycle n gives `tx_ev`/`rx_ev` high in cycle n+2, for exactly one cycle.
- Response latency:
  - `slave_tx_buffer` and `ptr` update at the edge ending the `tx_ev` cycle, i.e. valid in cycle n+3.
  - `rw_data` updates and `rw_wr_strobe` goes high in cycle n+3. The strobe is one cycle wide.
- `ro_data` is sampled at the edge ending the `tx_ev` cycle. It is not synchronised internally; the source must be in the `clk_core` domain.
- Deassert of `slave_asserted` in the same cycle as an event: the event is ignored and the FSM goes to IDLE.

## Structure
- Shared package `fc_config_pkg`:
  - FSM state encoding (IDLE/ADDR/DATA);
  - `FC_PTR_W`=8;
  - default slave address 7'h51.
- The only sub-module is the existing `i2c_slave`; no new sub-module.
- The edge detector is inline logic, two instances.

## Test plan
- Reset, NUM_RO=1, NUM_RW=2, RW_RESET=16'hA55A:
  - Release `reset_n` → `rw_data`=16'hA55A and strobes 0.
  - I2C read at ptr 0 with `ro_data`=8'h07 → returns 8'h07.
- Multi-byte write: START 0x51 W, bytes 01, 3C, C3 →
  - `rw_data`=16'hC33C;
  - `rw_wr_strobe` pulses bit0 then bit1, one cycle each;
  - ptr=0 after wrap.
- Write mask RW_WMASK=16'h00F0, write 0x01←FF over reset 00 → rw[0]=8'hF0, strobe[0] pulses.
- Read-only/out-of-range:
  - Write 00←55 → no change, no strobe.
  - Pointer 0x80 read → 8'h00.
  - Two reads from 0xFF → 00, then the byte at address 0.
- Burst read from ptr 0, 4 bytes → ro0, rw0, rw1, ro0 (wrap at NUM_REGS).
- Reset mid-write after the pointer byte 01 → no write occurs, FSM in IDLE, ptr=0, `rw_data`=RW_RESET.
